uart_tx_sequencer: RTL and testbench

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_counter.sv | 48 ++++
 rtl/uart_tx_sequencer.sv | 142 ++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit/receive blocks.
//   uart_state_e  : serial framing state encoding (IDLE/START/DATA/STOP)
//   DATA_BITS     : payload bits per character
//   BIT_IDX_W     : width of the data-bit index counter
//   LAST_BIT_IDX  : index value of the final data bit
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX = BIT_IDX_W'(DATA_BITS - 1);

endpackage : uart_pkg

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Counts clock cycles within one serial bit period (0..CLKS_PER_BIT-1) and
// flags the last cycle of each bit. Shared by the UART transmitter and receiver.
// Ports:
//   clk_i      : system clock, rising edge
//   rst_ni     : synchronous active-low reset
//   en_i       : count enable (high while a frame is in progress)
//   clr_i      : synchronous clear, takes precedence over en_i
//   bit_end_o  : high in the final cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end_o = en_i && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            // Wrap on the last cycle so consecutive bits line up with no gap.
            cnt_d = bit_end_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_baud_counter

// File: rtl/uart_tx_sequencer.sv
// -----------------------------------------------------------------------------
// uart_tx_sequencer
// Two-requester UART transmitter. A round-robin arbiter picks one pending
// byte at each accept point (idle, or the last cycle of a stop bit) and sends
// it as an LSB-first 8N1 frame. Back-to-back frames have no idle gap.
// Ports:
//   i_clock     : system clock, rising edge
//   i_resetL    : synchronous active-low reset
//   i_req[1:0]  : per-requester transmit request, held until acknowledged
//   i_data0/1   : byte offered by requester 0/1
//   o_ack[1:0]  : one-cycle pulse, byte n has been latched for transmission
//   o_tx        : serial line, idle high
//   o_busy      : a frame is in progress
//   o_grant_id  : requester whose byte is currently on the line
//   o_done      : pulse in the final cycle of each stop bit
// -----------------------------------------------------------------------------
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clock,
    input  logic       i_resetL,
    input  logic [1:0] i_req,
    input  logic [7:0] i_data0,
    input  logic [7:0] i_data1,
    output logic [1:0] o_ack,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_grant_id,
    output logic       o_done
);

    uart_state_e                state_q;
    uart_state_e                state_d;
    logic [BIT_IDX_W-1:0]       bit_idx_q;
    logic [BIT_IDX_W-1:0]       bit_idx_d;
    logic [DATA_BITS-1:0]       shreg_q;
    logic [DATA_BITS-1:0]       shreg_d;
    // Round-robin pointer: index of the requester that wins a tie next.
    logic                       rr_q;
    logic                       rr_d;

    logic                       bit_end;
    logic                       last_bit;
    logic                       accept;
    logic                       grant;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_i     (i_clock),
        .rst_ni    (i_resetL),
        .en_i      (state_q != ST_IDLE),
        .clr_i     (state_q == ST_IDLE),
        .bit_end_o (bit_end)
    );

    assign last_bit = (state_q == ST_DATA) && (bit_idx_q == LAST_BIT_IDX) && bit_end;

    // Accept is masked during reset so no byte is acknowledged without being latched.
    assign accept = i_resetL && (|i_req) &&
                    ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

    // Prioritised requester wins if asking, otherwise the other one.
    assign grant = i_req[rr_q] ? rr_q : ~rr_q;

    // ---------------- state register ----------------
    always_ff @(posedge i_clock) begin
        if (!i_resetL) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)   state_d = ST_START;
            ST_START: if (bit_end)  state_d = ST_DATA;
            ST_DATA:  if (last_bit) state_d = ST_STOP;
            ST_STOP:  if (bit_end)  state_d = accept ? ST_START : ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        o_tx       = 1'b1;
        o_busy     = (state_q != ST_IDLE);
        o_done     = (state_q == ST_STOP) && bit_end;
        // Pointer was set to the loser at grant time, so its complement is the sender.
        o_grant_id = (state_q != ST_IDLE) && !rr_q;
        o_ack      = 2'b00;
        case (state_q)
            ST_IDLE:  o_tx = 1'b1;
            ST_START: o_tx = 1'b0;
            ST_DATA:  o_tx = shreg_q[0];
            ST_STOP:  o_tx = 1'b1;
            default:  o_tx = 1'b1;
        endcase
        if (accept) begin
            o_ack = grant ? 2'b10 : 2'b01;
        end
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        rr_d      = rr_q;

        if (state_q != ST_DATA) begin
            bit_idx_d = '0;
        end else if (bit_end) begin
            // Wraps 7 -> 0 naturally on the last data bit.
            bit_idx_d = bit_idx_q + 1'b1;
        end

        if (accept) begin
            shreg_d = grant ? i_data1 : i_data0;
            rr_d    = ~grant;
        end else if ((state_q == ST_DATA) && bit_end && !last_bit) begin
            shreg_d = shreg_q >> 1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_resetL) begin
            bit_idx_q <= '0;
            shreg_q   <= '0;
            rr_q      <= 1'b0;
        end else begin
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            rr_q      <= rr_d;
        end
    end

endmodule : uart_tx_sequencer

// File: tb/tb_uart_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sequencer
// Directed bench for uart_tx_sequencer: one instance at 4 clocks/bit and one
// at 2 clocks/bit share the stimulus; a selector picks which one is observed.
// -----------------------------------------------------------------------------
module tb_uart_tx_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetL;
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       use_b;

    logic [1:0] ack_a, ack_b;
    logic       tx_a, tx_b, busy_a, busy_b, gid_a, gid_b, done_a, done_b;

    logic [1:0] ack;
    logic       tx, busy, gid, done;

    int total = 0;
    int bad   = 0;

    uart_tx_sequencer #(.CLKS_PER_BIT(4)) dut_a (
        .i_clock    (clk),
        .i_resetL   (resetL),
        .i_req      (req),
        .i_data0    (d0),
        .i_data1    (d1),
        .o_ack      (ack_a),
        .o_tx       (tx_a),
        .o_busy     (busy_a),
        .o_grant_id (gid_a),
        .o_done     (done_a)
    );

    uart_tx_sequencer #(.CLKS_PER_BIT(2)) dut_b (
        .i_clock    (clk),
        .i_resetL   (resetL),
        .i_req      (req),
        .i_data0    (d0),
        .i_data1    (d1),
        .o_ack      (ack_b),
        .o_tx       (tx_b),
        .o_busy     (busy_b),
        .o_grant_id (gid_b),
        .o_done     (done_b)
    );

    always_comb begin
        ack  = use_b ? ack_b  : ack_a;
        tx   = use_b ? tx_b   : tx_a;
        busy = use_b ? busy_b : busy_a;
        gid  = use_b ? gid_b  : gid_a;
        done = use_b ? done_b : done_a;
    end

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_ack;
        logic       exp_gid;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input string what, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s k=%0d: got %0h expected %0h", nm, what, k, act, exp);
        end
    endtask

    // Checks every cycle of one frame, starting the cycle after its accept.
    task automatic run_frame(input string nm, input int cpb, input logic [7:0] b,
                             input logic g, input logic [1:0] end_ack,
                             input logic [1:0] clr_mask, input int raise_k,
                             input logic [1:0] raise_mask);
        int   last;
        logic etx;
        last = 10 * cpb;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == 1) req = req & ~clr_mask;
            if (k == raise_k) req = req | raise_mask;
            #1;
            if (k <= cpb)          etx = 1'b0;
            else if (k <= 9 * cpb) etx = b[(k - cpb - 1) / cpb];
            else                   etx = 1'b1;
            chk(nm, "tx",   k, 32'(tx),   32'(etx));
            chk(nm, "busy", k, 32'(busy), 32'd1);
            chk(nm, "gid",  k, 32'(gid),  32'(g));
            chk(nm, "done", k, 32'(done), (k == last) ? 32'd1 : 32'd0);
            chk(nm, "ack",  k, 32'(ack),  (k == last) ? 32'(end_ack) : 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetL = 1'b0;
        req    = 2'b01;
        d0     = 8'h11;
        #1;
        chk("reset", "ack_in_rst", 0, 32'(ack), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetL = 1'b1;
        req    = 2'b00;
        #1;
        chk("reset", "tx",   0, 32'(tx),   32'd1);
        chk("reset", "busy", 0, 32'(busy), 32'd0);
        chk("reset", "ack",  0, 32'(ack),  32'd0);
        chk("reset", "done", 0, 32'(done), 32'd0);
        chk("reset", "gid",  0, 32'(gid),  32'd0);
    endtask

    task automatic idle_check(input string nm);
        @(negedge clk);
        #1;
        chk(nm, "idle_busy", 0, 32'(busy), 32'd0);
        chk(nm, "idle_tx",   0, 32'(tx),   32'd1);
    endtask

    initial begin
        resetL = 1'b0;
        req    = 2'b00;
        d0     = 8'h00;
        d1     = 8'h00;
        use_b  = 1'b0;

        // Single frames from idle; withdrawn losers are never sent.
        vecs[0] = '{req: 2'b01, d0: 8'h55, d1: 8'h00, exp_ack: 2'b01, exp_gid: 1'b0, exp_byte: 8'h55};
        vecs[1] = '{req: 2'b10, d0: 8'h00, d1: 8'hC3, exp_ack: 2'b10, exp_gid: 1'b1, exp_byte: 8'hC3};
        vecs[2] = '{req: 2'b11, d0: 8'h0F, d1: 8'hF0, exp_ack: 2'b01, exp_gid: 1'b0, exp_byte: 8'h0F};
        vecs[3] = '{req: 2'b11, d0: 8'h12, d1: 8'h81, exp_ack: 2'b10, exp_gid: 1'b1, exp_byte: 8'h81};
        vecs[4] = '{req: 2'b10, d0: 8'h00, d1: 8'hA0, exp_ack: 2'b10, exp_gid: 1'b1, exp_byte: 8'hA0};
        vecs[5] = '{req: 2'b11, d0: 8'h3C, d1: 8'h77, exp_ack: 2'b01, exp_gid: 1'b0, exp_byte: 8'h3C};
        vecs[6] = '{req: 2'b01, d0: 8'hFF, d1: 8'h00, exp_ack: 2'b01, exp_gid: 1'b0, exp_byte: 8'hFF};
        vecs[7] = '{req: 2'b00, d0: 8'h99, d1: 8'h66, exp_ack: 2'b00, exp_gid: 1'b0, exp_byte: 8'h00};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            string vn;
            vn = $sformatf("vec%0d", i);
            @(negedge clk);
            req = vecs[i].req;
            d0  = vecs[i].d0;
            d1  = vecs[i].d1;
            #1;
            chk(vn, "busy_pre", 0, 32'(busy), 32'd0);
            chk(vn, "ack",      0, 32'(ack),  32'(vecs[i].exp_ack));
            if (vecs[i].exp_ack != 2'b00) begin
                run_frame(vn, 4, vecs[i].exp_byte, vecs[i].exp_gid, 2'b00, vecs[i].req, 0, 2'b00);
            end else begin
                @(negedge clk);
                req = 2'b00;
                #1;
                chk(vn, "no_req_busy", 0, 32'(busy), 32'd0);
            end
        end
        idle_check("vec_end");

        // Both requesting after reset: alternating grants, back-to-back frames.
        do_reset();
        @(negedge clk);
        req = 2'b11;
        d0  = 8'hA5;
        d1  = 8'h3C;
        #1;
        chk("rr0", "ack", 0, 32'(ack), 32'd1);
        run_frame("rr1", 4, 8'hA5, 1'b0, 2'b10, 2'b00, 0, 2'b00);
        run_frame("rr2", 4, 8'h3C, 1'b1, 2'b01, 2'b00, 0, 2'b00);
        run_frame("rr3", 4, 8'hA5, 1'b0, 2'b10, 2'b00, 0, 2'b00);
        run_frame("rr4", 4, 8'h3C, 1'b1, 2'b00, 2'b11, 0, 2'b00);
        idle_check("rr_end");

        // Requester 1 arrives mid-DATA: held off until the final stop cycle.
        do_reset();
        @(negedge clk);
        req = 2'b01;
        d0  = 8'h96;
        d1  = 8'h5A;
        #1;
        chk("mid0", "ack", 0, 32'(ack), 32'd1);
        run_frame("mid1", 4, 8'h96, 1'b0, 2'b10, 2'b01, 20, 2'b10);
        run_frame("mid2", 4, 8'h5A, 1'b1, 2'b00, 2'b10, 0, 2'b00);
        idle_check("mid_end");

        // Reset pulse during data bit 3 aborts the frame.
        do_reset();
        @(negedge clk);
        req = 2'b01;
        d0  = 8'hE7;
        #1;
        chk("abort", "ack", 0, 32'(ack), 32'd1);
        for (int k = 1; k <= 18; k++) begin
            logic etx;
            @(negedge clk);
            if (k == 1) req = 2'b00;
            #1;
            etx = (k <= 4) ? 1'b0 : d0[(k - 5) / 4];
            chk("abort", "tx", k, 32'(tx), 32'(etx));
        end
        resetL = 1'b0;
        @(negedge clk);
        resetL = 1'b1;
        #1;
        chk("abort", "tx_after",   0, 32'(tx),   32'd1);
        chk("abort", "busy_after", 0, 32'(busy), 32'd0);
        chk("abort", "done_after", 0, 32'(done), 32'd0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            #1;
            chk("abort_quiet", "done", k, 32'(done), 32'd0);
            chk("abort_quiet", "busy", k, 32'(busy), 32'd0);
            chk("abort_quiet", "ack",  k, 32'(ack),  32'd0);
        end
        @(negedge clk);
        req = 2'b10;
        d1  = 8'h4B;
        #1;
        chk("post_abort", "ack", 0, 32'(ack), 32'd2);
        run_frame("post_abort", 4, 8'h4B, 1'b1, 2'b00, 2'b10, 0, 2'b00);
        idle_check("post_abort_end");

        // Two clocks per bit: 0x00 then 0xFF back-to-back.
        use_b = 1'b1;
        do_reset();
        @(negedge clk);
        req = 2'b01;
        d0  = 8'h00;
        d1  = 8'hFF;
        #1;
        chk("cpb2_0", "ack", 0, 32'(ack), 32'd1);
        run_frame("cpb2_f1", 2, 8'h00, 1'b0, 2'b10, 2'b01, 5, 2'b10);
        run_frame("cpb2_f2", 2, 8'hFF, 1'b1, 2'b00, 2'b10, 0, 2'b00);
        idle_check("cpb2_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_tx_sequencer
